// File: rtl/ffe_data_memory_arbiter.sv
// Two-port ownership arbiter for the FFE data memory: Req/Grant handshake, mux Select,
// turnaround drain on every ownership change, and per-port read-data-valid strobes.
module ffe_data_memory_arbiter #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_BURST    = 16,
  parameter bit          ROUND_ROBIN  = 1'b1
) (
  input  logic ClockIn,
  input  logic ResetIn_n,
  input  logic Req0,
  input  logic Req1,
  input  logic ReadEnable0,
  input  logic ReadEnable1,
  output logic Grant0,
  output logic Grant1,
  output logic Select,
  output logic RdValid0,
  output logic RdValid1,
  output logic Busy
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 2);
  localparam logic [CntW-1:0] BurstMax = CntW'(MAX_BURST);
  localparam logic [2:0]      DrainLen = 3'(READ_LATENCY);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1, StDrain} state_e;

  state_e                  state_q, state_d;
  logic                    last_owner_q, last_owner_d;
  logic [CntW-1:0]         burst_q, burst_d;
  logic [2:0]              drain_q, drain_d;
  logic                    grant0_q, grant0_d;
  logic                    grant1_q, grant1_d;
  logic                    select_q, select_d;
  logic                    busy_q, busy_d;
  logic [READ_LATENCY-1:0] pipe0_q, pipe0_d;
  logic [READ_LATENCY-1:0] pipe1_q, pipe1_d;
  logic                    preempt0, preempt1;

  // State register
  always_ff @(posedge ClockIn) begin
    if (!ResetIn_n) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;
      burst_q      <= '0;
      drain_q      <= '0;
      grant0_q     <= 1'b0;
      grant1_q     <= 1'b0;
      select_q     <= 1'b0;
      busy_q       <= 1'b0;
      pipe0_q      <= '0;
      pipe1_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_q      <= burst_d;
      drain_q      <= drain_d;
      grant0_q     <= grant0_d;
      grant1_q     <= grant1_d;
      select_q     <= select_d;
      busy_q       <= busy_d;
      pipe0_q      <= pipe0_d;
      pipe1_q      <= pipe1_d;
    end
  end

  assign preempt0 = (MAX_BURST != 0) && Req1 && (burst_q == BurstMax);
  assign preempt1 = (MAX_BURST != 0) && Req0 && (burst_q == BurstMax);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (Req0 && Req1) begin
          state_d = (ROUND_ROBIN && !last_owner_q) ? StGrant1 : StGrant0;
        end else if (Req0) begin
          state_d = StGrant0;
        end else if (Req1) begin
          state_d = StGrant1;
        end
      end
      StGrant0: if (!Req0 || preempt0) state_d = StDrain;
      StGrant1: if (!Req1 || preempt1) state_d = StDrain;
      StDrain: begin
        // The port that did not own the memory gets first pick out of the drain.
        if (drain_q == DrainLen) begin
          if (select_q) begin
            state_d = Req0 ? StGrant0 : (Req1 ? StGrant1 : StIdle);
          end else begin
            state_d = Req1 ? StGrant1 : (Req0 ? StGrant0 : StIdle);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output and bookkeeping logic, registered from the next state
  always_comb begin
    grant0_d     = (state_d == StGrant0);
    grant1_d     = (state_d == StGrant1);
    busy_d       = (state_d != StIdle);
    select_d     = select_q;
    last_owner_d = last_owner_q;
    if (state_d == StGrant0) begin
      select_d     = 1'b0;
      last_owner_d = 1'b0;
    end else if (state_d == StGrant1) begin
      select_d     = 1'b1;
      last_owner_d = 1'b1;
    end

    burst_d = '0;
    if (grant0_d || grant1_d) begin
      if (state_d != state_q) begin
        burst_d = {{(CntW-1){1'b0}}, 1'b1};
      end else if (burst_q != {CntW{1'b1}}) begin
        burst_d = burst_q + 1'b1;
      end else begin
        burst_d = burst_q;
      end
    end

    drain_d = '0;
    if (state_d == StDrain) begin
      drain_d = (state_q == StDrain) ? drain_q + 3'd1 : 3'd1;
    end

    // Accepted reads travel READ_LATENCY stages; the last stage is the valid strobe.
    pipe0_d    = pipe0_q << 1;
    pipe1_d    = pipe1_q << 1;
    pipe0_d[0] = !select_q && grant0_q && ReadEnable0;
    pipe1_d[0] = select_q && grant1_q && ReadEnable1;
  end

  assign Grant0   = grant0_q;
  assign Grant1   = grant1_q;
  assign Select   = select_q;
  assign Busy     = busy_q;
  assign RdValid0 = pipe0_q[READ_LATENCY-1];
  assign RdValid1 = pipe1_q[READ_LATENCY-1];

endmodule
